// File: rtl/id_ex_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU op codes,
// forwarding selects, register-index type and the registered control bundle.
package id_ex_reg_pkg;

    typedef logic [4:0] reg_idx_t;
    typedef logic [2:0] alu_op_t;
    typedef logic [1:0] fwd_sel_t;

    localparam alu_op_t ALU_AND = 3'b000;
    localparam alu_op_t ALU_OR  = 3'b001;
    localparam alu_op_t ALU_ADD = 3'b010;
    localparam alu_op_t ALU_SUB = 3'b110;
    localparam alu_op_t ALU_SLE = 3'b111;

    localparam fwd_sel_t FWD_REG = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    // All-zero value of this struct is a bubble.
    typedef struct packed {
        logic    valid;
        logic    regwrite;
        logic    memwrite;
        logic    memtoreg;
        logic    alusrc;
        alu_op_t alucontrol;
    } ctrl_t;

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode-side inputs, forwarding inputs and execute-side outputs of the
// ID/EX register; master is the pipeline driving it, slave is the register.
interface id_ex_if
    import id_ex_reg_pkg::*;
#(parameter int DW = 32);

    logic          id_valid;
    logic [DW-1:0] id_rd1, id_rd2, id_imm;
    reg_idx_t      id_rs, id_rt, id_rd;
    alu_op_t       id_alucontrol;
    logic          id_alusrc, id_regdst, id_regwrite, id_memwrite, id_memtoreg;

    logic [DW-1:0] mem_result, wb_result;
    fwd_sel_t      fwd_a, fwd_b;

    logic [DW-1:0] src_a, src_b, ex_store_data;
    alu_op_t       ex_alucontrol;
    reg_idx_t      ex_writereg, ex_rs, ex_rt;
    logic          ex_valid, ex_regwrite, ex_memwrite, ex_memtoreg;

    modport master (
        output id_valid, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
               id_alucontrol, id_alusrc, id_regdst, id_regwrite,
               id_memwrite, id_memtoreg, mem_result, wb_result, fwd_a, fwd_b,
        input  src_a, src_b, ex_store_data, ex_alucontrol, ex_writereg,
               ex_rs, ex_rt, ex_valid, ex_regwrite, ex_memwrite, ex_memtoreg
    );

    modport slave (
        input  id_valid, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
               id_alucontrol, id_alusrc, id_regdst, id_regwrite,
               id_memwrite, id_memtoreg, mem_result, wb_result, fwd_a, fwd_b,
        output src_a, src_b, ex_store_data, ex_alucontrol, ex_writereg,
               ex_rs, ex_rt, ex_valid, ex_regwrite, ex_memwrite, ex_memtoreg
    );

endinterface

// File: rtl/id_ex_reg_fwd_mux.sv
// 3:1 forwarding mux: registered operand, WB result or MEM result.
module fwd_mux
    import id_ex_reg_pkg::*;
#(parameter int DW = 32)
(
    input  fwd_sel_t      sel,
    input  logic [DW-1:0] reg_val,
    input  logic [DW-1:0] wb_val,
    input  logic [DW-1:0] mem_val,
    output logic [DW-1:0] y
);

    always_comb begin
        case (sel)
            FWD_WB:  y = wb_val;
            FWD_MEM: y = mem_val;
            default: y = reg_val;
        endcase
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush > stall > load priority and
// combinational operand forwarding. Optional bubble counter: ID_EX_BUBBLE_CNT_EN.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(parameter int DW = 32)
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   stall,
    input  logic   flush,
    id_ex_if.slave bus
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [15:0] bubble_cnt
`endif
);

    ctrl_t         ctrl_q, ctrl_d;
    logic [DW-1:0] rd1_q, rd2_q, imm_q;
    reg_idx_t      rs_q, rt_q, wr_q;

    // An invalid instruction is loaded with its side-effect controls cleared.
    always_comb begin
        ctrl_d            = '0;
        ctrl_d.valid      = bus.id_valid;
        ctrl_d.regwrite   = bus.id_valid & bus.id_regwrite;
        ctrl_d.memwrite   = bus.id_valid & bus.id_memwrite;
        ctrl_d.memtoreg   = bus.id_valid & bus.id_memtoreg;
        ctrl_d.alusrc     = bus.id_alusrc;
        ctrl_d.alucontrol = bus.id_alucontrol;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            ctrl_q <= '0;
            rd1_q  <= '0;
            rd2_q  <= '0;
            imm_q  <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            wr_q   <= '0;
        end else if (!stall) begin
            ctrl_q <= ctrl_d;
            rd1_q  <= bus.id_rd1;
            rd2_q  <= bus.id_rd2;
            imm_q  <= bus.id_imm;
            rs_q   <= bus.id_rs;
            rt_q   <= bus.id_rt;
            wr_q   <= bus.id_regdst ? bus.id_rd : bus.id_rt;
        end
    end

    logic [DW-1:0] fwd_rs, fwd_rt;

    fwd_mux #(.DW(DW)) u_fwd_a (
        .sel(bus.fwd_a), .reg_val(rd1_q), .wb_val(bus.wb_result),
        .mem_val(bus.mem_result), .y(fwd_rs)
    );

    fwd_mux #(.DW(DW)) u_fwd_b (
        .sel(bus.fwd_b), .reg_val(rd2_q), .wb_val(bus.wb_result),
        .mem_val(bus.mem_result), .y(fwd_rt)
    );

    assign bus.src_a         = fwd_rs;
    assign bus.ex_store_data = fwd_rt;
    assign bus.src_b         = ctrl_q.alusrc ? imm_q : fwd_rt;
    assign bus.ex_alucontrol = ctrl_q.alucontrol;
    assign bus.ex_writereg   = wr_q;
    assign bus.ex_rs         = rs_q;
    assign bus.ex_rt         = rt_q;
    assign bus.ex_valid      = ctrl_q.valid;
    assign bus.ex_regwrite   = ctrl_q.regwrite;
    assign bus.ex_memwrite   = ctrl_q.memwrite;
    assign bus.ex_memtoreg   = ctrl_q.memtoreg;

`ifdef ID_EX_BUBBLE_CNT_EN
    // A bubble enters the stage on a flush or on an unstalled invalid load.
    logic bubble_cap;
    assign bubble_cap = flush | (~stall & ~bus.id_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_cnt <= '0;
        else if (bubble_cap && bubble_cnt != 16'hFFFF)
            bubble_cnt <= bubble_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg; build with +define+ID_EX_BUBBLE_CNT_EN
// to also cover the bubble counter.
module tb_id_ex_reg;
    import id_ex_reg_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    int   total = 0;
    int   bad = 0;

    id_ex_if #(.DW(32)) bus();

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
`endif

    id_ex_reg #(.DW(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .bus(bus)
`ifdef ID_EX_BUBBLE_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic valid, input logic [31:0] rd1, rd2, imm,
                          input logic [4:0] rs, rt, rd, input logic [2:0] aluc,
                          input logic alusrc, regdst, regwrite, memwrite, memtoreg);
        bus.id_valid = valid;   bus.id_rd1 = rd1;   bus.id_rd2 = rd2;
        bus.id_imm = imm;       bus.id_rs = rs;     bus.id_rt = rt;
        bus.id_rd = rd;         bus.id_alucontrol = aluc;
        bus.id_alusrc = alusrc; bus.id_regdst = regdst;
        bus.id_regwrite = regwrite; bus.id_memwrite = memwrite;
        bus.id_memtoreg = memtoreg;
    endtask

    task automatic test_reset();
        set_id(1'b1, 32'h1234, 32'h5678, 32'h9, 5'd1, 5'd2, 5'd3, ALU_ADD,
               1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        bus.mem_result = '0; bus.wb_result = '0;
        bus.fwd_a = FWD_REG; bus.fwd_b = FWD_REG;
        tick(); tick();
        total++; if (bus.ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.ex_valid); end
        total++; if (bus.src_a !== 32'h0) begin bad++; $display("FAIL reset_src_a got=%h exp=0", bus.src_a); end
        total++; if (bus.src_b !== 32'h0) begin bad++; $display("FAIL reset_src_b got=%h exp=0", bus.src_b); end
        total++; if ({bus.ex_regwrite, bus.ex_memwrite, bus.ex_memtoreg, bus.ex_writereg} !== 8'h0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0", {bus.ex_regwrite, bus.ex_memwrite, bus.ex_memtoreg, bus.ex_writereg});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_load();
        set_id(1'b1, 32'd5, 32'd7, 32'h99, 5'd1, 5'd2, 5'd3, ALU_ADD,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (bus.src_a !== 32'd0) begin bad++; $display("FAIL load_latency got=%h exp=0", bus.src_a); end
        tick();
        total++; if (bus.src_a !== 32'd5) begin bad++; $display("FAIL load_src_a got=%h exp=5", bus.src_a); end
        total++; if (bus.src_b !== 32'd7) begin bad++; $display("FAIL load_src_b got=%h exp=7", bus.src_b); end
        total++; if (bus.ex_alucontrol !== ALU_ADD) begin bad++; $display("FAIL load_aluc got=%b exp=010", bus.ex_alucontrol); end
        total++; if (bus.ex_writereg !== 5'd3) begin bad++; $display("FAIL load_writereg got=%0d exp=3", bus.ex_writereg); end
        total++; if ({bus.ex_valid, bus.ex_regwrite} !== 2'b11) begin bad++; $display("FAIL load_ctrl got=%b exp=11", {bus.ex_valid, bus.ex_regwrite}); end
        total++; if ({bus.ex_rs, bus.ex_rt} !== {5'd1, 5'd2}) begin bad++; $display("FAIL load_rs_rt got=%0d,%0d exp=1,2", bus.ex_rs, bus.ex_rt); end
    endtask

    task automatic test_forward();
        bus.mem_result = 32'h100; bus.fwd_a = FWD_MEM; #1;
        total++; if (bus.src_a !== 32'h100) begin bad++; $display("FAIL fwd_a_mem got=%h exp=100", bus.src_a); end
        bus.wb_result = 32'h200; bus.fwd_a = FWD_WB; #1;
        total++; if (bus.src_a !== 32'h200) begin bad++; $display("FAIL fwd_a_wb got=%h exp=200", bus.src_a); end
        bus.fwd_a = 2'b11; #1;
        total++; if (bus.src_a !== 32'd5) begin bad++; $display("FAIL fwd_a_11 got=%h exp=5", bus.src_a); end
        bus.fwd_b = FWD_MEM; #1;
        total++; if (bus.src_b !== 32'h100 || bus.ex_store_data !== 32'h100) begin
            bad++; $display("FAIL fwd_b_mem got=%h/%h exp=100/100", bus.src_b, bus.ex_store_data);
        end
        bus.fwd_a = FWD_REG; bus.fwd_b = FWD_REG;
        tick();
    endtask

    task automatic test_stall();
        stall = 1'b1;
        set_id(1'b1, 32'h11, 32'h22, 32'h0, 5'd4, 5'd5, 5'd9, ALU_SUB,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.src_a !== 32'd5 || bus.src_b !== 32'd7 || bus.ex_alucontrol !== ALU_ADD) begin
                bad++; $display("FAIL stall_hold%0d got=%h/%h/%b exp=5/7/010", i, bus.src_a, bus.src_b, bus.ex_alucontrol);
            end
        end
        stall = 1'b0;
        tick();
        total++; if (bus.src_a !== 32'h11 || bus.src_b !== 32'h22 || bus.ex_alucontrol !== ALU_SUB || bus.ex_writereg !== 5'd9) begin
            bad++; $display("FAIL stall_release got=%h/%h/%b/%0d exp=11/22/110/9", bus.src_a, bus.src_b, bus.ex_alucontrol, bus.ex_writereg);
        end
    endtask

    task automatic test_flush_stall();
        set_id(1'b1, 32'h44, 32'h55, 32'h0, 5'd6, 5'd7, 5'd8, ALU_OR,
               1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        total++; if ({bus.ex_valid, bus.ex_regwrite, bus.ex_memwrite, bus.ex_memtoreg} !== 4'b0) begin
            bad++; $display("FAIL flush_ctrl got=%b exp=0000", {bus.ex_valid, bus.ex_regwrite, bus.ex_memwrite, bus.ex_memtoreg});
        end
        total++; if (bus.ex_writereg !== 5'd0 || bus.src_a !== 32'd0 || bus.ex_alucontrol !== 3'd0) begin
            bad++; $display("FAIL flush_data got=%0d/%h/%b exp=0/0/000", bus.ex_writereg, bus.src_a, bus.ex_alucontrol);
        end
    endtask

    task automatic test_invalid_load();
        set_id(1'b0, 32'h33, 32'h0, 32'h0, 5'd1, 5'd12, 5'd13, ALU_SLE,
               1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        total++; if ({bus.ex_valid, bus.ex_regwrite, bus.ex_memwrite, bus.ex_memtoreg} !== 4'b0) begin
            bad++; $display("FAIL bubble_ctrl got=%b exp=0000", {bus.ex_valid, bus.ex_regwrite, bus.ex_memwrite, bus.ex_memtoreg});
        end
        total++; if (bus.src_a !== 32'h33 || bus.ex_writereg !== 5'd12 || bus.ex_alucontrol !== ALU_SLE) begin
            bad++; $display("FAIL bubble_fields got=%h/%0d/%b exp=33/12/111", bus.src_a, bus.ex_writereg, bus.ex_alucontrol);
        end
    endtask

    task automatic test_store();
        set_id(1'b1, 32'h1, 32'h55, 32'hFFFF_FFFC, 5'd2, 5'd4, 5'd7, ALU_ADD,
               1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        bus.fwd_b = FWD_WB; bus.wb_result = 32'hAA;
        tick();
        total++; if (bus.src_b !== 32'hFFFF_FFFC) begin bad++; $display("FAIL store_src_b got=%h exp=fffffffc", bus.src_b); end
        total++; if (bus.ex_store_data !== 32'hAA) begin bad++; $display("FAIL store_data_fwd got=%h exp=aa", bus.ex_store_data); end
        total++; if (bus.ex_writereg !== 5'd4 || bus.ex_memwrite !== 1'b1 || bus.ex_regwrite !== 1'b0) begin
            bad++; $display("FAIL store_ctrl got=%0d/%b/%b exp=4/1/0", bus.ex_writereg, bus.ex_memwrite, bus.ex_regwrite);
        end
        bus.fwd_b = FWD_REG; #1;
        total++; if (bus.ex_store_data !== 32'h55) begin bad++; $display("FAIL store_data_reg got=%h exp=55", bus.ex_store_data); end
    endtask

    task automatic test_async_reset();
        set_id(1'b1, 32'h77, 32'h88, 32'h0, 5'd3, 5'd4, 5'd5, ALU_AND,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        total++; if (bus.ex_regwrite !== 1'b1 || bus.src_a !== 32'h77) begin
            bad++; $display("FAIL pre_areset got=%b/%h exp=1/77", bus.ex_regwrite, bus.src_a);
        end
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({bus.ex_valid, bus.ex_regwrite, bus.ex_writereg} !== 7'b0 || bus.src_a !== 32'd0 || bus.src_b !== 32'd0) begin
            bad++; $display("FAIL async_reset got=%b/%h/%h exp=0/0/0", {bus.ex_valid, bus.ex_regwrite, bus.ex_writereg}, bus.src_a, bus.src_b);
        end
        tick();
        total++; if (bus.ex_valid !== 1'b0 || bus.src_a !== 32'd0) begin
            bad++; $display("FAIL reset_over_stall got=%b/%h exp=0/0", bus.ex_valid, bus.src_a);
        end
`ifdef ID_EX_BUBBLE_CNT_EN
        total++; if (bubble_cnt !== 16'd0) begin bad++; $display("FAIL bcnt_reset got=%0d exp=0", bubble_cnt); end
`endif
        rst_n = 1'b1; stall = 1'b0;
        tick();
        total++; if (bus.src_a !== 32'h77 || bus.ex_valid !== 1'b1) begin
            bad++; $display("FAIL post_reset_load got=%h/%b exp=77/1", bus.src_a, bus.ex_valid);
        end
    endtask

`ifdef ID_EX_BUBBLE_CNT_EN
    task automatic test_bubble_cnt();
        flush = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        flush = 1'b0;
        tick();
        total++; if (bubble_cnt !== 16'd3) begin bad++; $display("FAIL bcnt_flush got=%0d exp=3", bubble_cnt); end
        bus.id_valid = 1'b0;
        tick();
        bus.id_valid = 1'b1;
        total++; if (bubble_cnt !== 16'd4) begin bad++; $display("FAIL bcnt_invalid got=%0d exp=4", bubble_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_forward();
        test_stall();
        test_flush_stall();
        test_invalid_load();
        test_store();
        test_async_reset();
`ifdef ID_EX_BUBBLE_CNT_EN
        test_bubble_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
